ofdm_symbol_sync_ma: RTL and testbench

Parametrised OFDM symbol synchroniser that sits between the ADC sample stream and the FFT front end.
- Detects a symbol boundary from the difference between a long and a short sliding-window mean of the sync channel.
- Forwards a framed packet of one or more symbols on an Avalon-ST source, with optional cyclic-prefix removal.
- Drives the sampling-control feedback and a sample-clock phase-reset pulse on lock.
- Successor to the fixed-length block-average synchroniser: true sliding windows, configurable widths and lengths, multi-symbol packets, re-arm holdoff.

---
 rtl/ofdm_symbol_sync_ma.sv | 221 ++++++++++++++++++++++
 tb/tb_ofdm_symbol_sync_ma.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_sync_ma.sv
// ofdm_symbol_sync_ma
// OFDM symbol synchroniser. It keeps a long and a short sliding-window mean of
// the sync channel (I, sign-extended). A symbol boundary is declared when
// |long mean - short mean| exceeds THRESHOLD. After that boundary it forwards a
// framed packet of SYMBOLS_PER_PKT symbols on an Avalon-ST source, then holds
// off for HOLDOFF valid samples and re-arms.
// Optional feature: define OFDM_SYNC_CP_STRIP_EN to discard CP_LEN
// cyclic-prefix samples at the start of each symbol.
module ofdm_symbol_sync_ma #(
    parameter int DATA_W          = 16,
    parameter int LONG_LOG2       = 5,
    parameter int SHORT_LOG2      = 2,
    parameter int THRESHOLD       = 100,
    parameter int SYMBOL_LEN      = 32,
    parameter int SYMBOLS_PER_PKT = 1,
    parameter int CP_LEN          = 8,
    parameter int HOLDOFF         = 16
) (
    input  logic                  clock_clk,
    input  logic                  reset_reset,
    input  logic [2*DATA_W-1:0]   asi_in0_data,
    input  logic                  asi_in0_valid,
    output logic [2*DATA_W-1:0]   aso_out0_data,
    output logic                  aso_out0_valid,
    output logic                  aso_out0_startofpacket,
    output logic                  aso_out0_endofpacket,
    output logic                  pre_sampling,
    output logic                  sample_clock_reset,
    output logic                  sync_lock,
    output logic [15:0]           symbol_index
);

    localparam int SW      = DATA_W + LONG_LOG2 + 1;
    localparam int LONG_N  = 1 << LONG_LOG2;
    localparam int SHORT_N = 1 << SHORT_LOG2;
`ifdef OFDM_SYNC_CP_STRIP_EN
    localparam int CP_EFF  = CP_LEN;
`else
    // Without CP strip the prefix length has no effect.
    localparam int CP_EFF  = 0 * CP_LEN;
`endif
    localparam int SYM_IN  = CP_EFF + SYMBOL_LEN;

    localparam logic [31:0]   FILL_LAST = 32'(LONG_N - 1);
    localparam logic [31:0]   CP_U      = 32'(CP_EFF);
    localparam logic [31:0]   SYM_LAST  = 32'(SYM_IN - 1);
    localparam logic [31:0]   HOLD_LAST = 32'(HOLDOFF - 1);
    localparam logic [15:0]   PKT_LAST  = 16'(SYMBOLS_PER_PKT - 1);
    localparam logic [SW-1:0] THR       = SW'(THRESHOLD);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t state, state_nx;

    logic signed [DATA_W-1:0] dline [LONG_N];
    logic signed [SW-1:0]     lsum, ssum, lsum_nx, ssum_nx;
    logic signed [SW-1:0]     x_ext, metric, metric_abs;
    logic [31:0]              cnt, cnt_nx;
    logic [15:0]              sym, sym_nx;
    logic                     trig, fwd, sop, eop, clr;

    // Sliding-window sums and the detection metric, including the current sample
    always_comb begin
        x_ext      = SW'($signed(asi_in0_data[DATA_W-1:0]));
        lsum_nx    = lsum + x_ext - SW'(dline[LONG_N-1]);
        ssum_nx    = ssum + x_ext - SW'(dline[SHORT_N-1]);
        metric     = (lsum_nx >>> LONG_LOG2) - (ssum_nx >>> SHORT_LOG2);
        metric_abs = metric[SW-1] ? -metric : metric;
    end

    // Next-state, counter and framing decode; nothing advances on invalid cycles
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sym_nx   = sym;
        trig     = 1'b0;
        fwd      = 1'b0;
        sop      = 1'b0;
        eop      = 1'b0;
        clr      = 1'b0;
        if (asi_in0_valid) begin
            case (state)
                ST_FILL: begin
                    if (cnt == FILL_LAST) begin
                        state_nx = ST_SEARCH;
                        cnt_nx   = 32'd0;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                ST_SEARCH: begin
                    if (metric_abs > THR) begin
                        state_nx = ST_CAPTURE;
                        trig     = 1'b1;
                        cnt_nx   = 32'd0;
                        sym_nx   = 16'd0;
                    end else begin
                        state_nx = ST_SEARCH;
                    end
                end
                ST_CAPTURE: begin
                    // cnt is the position within the current symbol, CP included
                    fwd = (cnt >= CP_U);
                    sop = fwd && (sym == 16'd0) && (cnt == CP_U);
                    if (cnt == SYM_LAST) begin
                        cnt_nx = 32'd0;
                        sym_nx = sym + 16'd1;
                        if (sym == PKT_LAST) begin
                            eop = 1'b1;
                            if (HOLDOFF == 0) begin
                                clr      = 1'b1;
                                sym_nx   = 16'd0;
                                state_nx = ST_FILL;
                            end else begin
                                state_nx = ST_HOLDOFF;
                            end
                        end else begin
                            state_nx = ST_CAPTURE;
                        end
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        clr      = 1'b1;
                        state_nx = ST_FILL;
                        cnt_nx   = 32'd0;
                        sym_nx   = 16'd0;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                default: begin
                    clr      = 1'b1;
                    state_nx = ST_FILL;
                    cnt_nx   = 32'd0;
                    sym_nx   = 16'd0;
                end
            endcase
        end else begin
            state_nx = state;
        end
    end

    // State and counter registers
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= ST_FILL;
            cnt   <= 32'd0;
            sym   <= 16'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sym   <= sym_nx;
        end
    end

    // Delay line and running sums; cleared to zero on re-arm
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            lsum <= '0;
            ssum <= '0;
            for (int i = 0; i < LONG_N; i++) begin
                dline[i] <= '0;
            end
        end else if (asi_in0_valid) begin
            if (clr) begin
                lsum <= '0;
                ssum <= '0;
                for (int i = 0; i < LONG_N; i++) begin
                    dline[i] <= '0;
                end
            end else begin
                lsum     <= lsum_nx;
                ssum     <= ssum_nx;
                dline[0] <= $signed(asi_in0_data[DATA_W-1:0]);
                for (int i = 1; i < LONG_N; i++) begin
                    dline[i] <= dline[i-1];
                end
            end
        end else begin
            lsum <= lsum;
        end
    end

    // Registered stream outputs and status flags
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            aso_out0_data          <= '0;
            aso_out0_valid         <= 1'b0;
            aso_out0_startofpacket <= 1'b0;
            aso_out0_endofpacket   <= 1'b0;
            pre_sampling           <= 1'b1;
            sample_clock_reset     <= 1'b0;
            sync_lock              <= 1'b0;
            symbol_index           <= 16'd0;
        end else begin
            aso_out0_valid         <= fwd;
            aso_out0_startofpacket <= sop;
            aso_out0_endofpacket   <= eop;
            sample_clock_reset     <= trig;
            sync_lock              <= (state_nx == ST_CAPTURE);
            pre_sampling           <= (state_nx != ST_CAPTURE);
            if (fwd) begin
                aso_out0_data <= asi_in0_data;
                symbol_index  <= sym;
            end else if (clr) begin
                symbol_index  <= 16'd0;
            end else begin
                symbol_index  <= symbol_index;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_sync_ma.sv
// Self-checking bench for ofdm_symbol_sync_ma: directed steps from the test
// plan followed by randomized traffic, checked against a reference model that
// computes window means directly from a history queue.
module tb_ofdm_symbol_sync_ma;

    localparam int DW   = 16;
    localparam int LL   = 5;
    localparam int SL   = 2;
    localparam int THR  = 100;
    localparam int SYM  = 16;
    localparam int SPP  = 2;
    localparam int HOLD = 16;
`ifdef OFDM_SYNC_CP_STRIP_EN
    localparam int CPL  = 8;
`else
    localparam int CPL  = 0;
`endif
    localparam int LN   = 1 << LL;
    localparam int SN   = 1 << SL;
    localparam int NPKT = SYM * SPP;

    localparam int M_FILL = 0;
    localparam int M_SRCH = 1;
    localparam int M_CAP  = 2;
    localparam int M_HOLD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        vin;
    logic [31:0] dout;
    logic        vout, sop, eop, pre, scr, lock;
    logic [15:0] symidx;

    always #5 clk = ~clk;

    ofdm_symbol_sync_ma #(
        .DATA_W(DW), .LONG_LOG2(LL), .SHORT_LOG2(SL), .THRESHOLD(THR),
        .SYMBOL_LEN(SYM), .SYMBOLS_PER_PKT(SPP), .CP_LEN(8), .HOLDOFF(HOLD)
    ) dut (
        .clock_clk(clk), .reset_reset(rst),
        .asi_in0_data(din), .asi_in0_valid(vin),
        .aso_out0_data(dout), .aso_out0_valid(vout),
        .aso_out0_startofpacket(sop), .aso_out0_endofpacket(eop),
        .pre_sampling(pre), .sample_clock_reset(scr), .sync_lock(lock),
        .symbol_index(symidx)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // reference model state
    int          hist[$];
    int          mode, cnt, fwd_k;
    bit          e_valid, e_sop, e_eop, e_scr;
    logic [31:0] e_data;
    int          e_sym;

    // observation counters for directed claims
    int obs_valid, obs_sop, obs_eop, obs_scr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic model_reset();
        hist.delete();
        mode = M_FILL; cnt = 0; fwd_k = 0;
        e_valid = 0; e_sop = 0; e_eop = 0; e_scr = 0; e_data = '0; e_sym = 0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d);
        int x, ls, ss, dm, pos, symn;
        e_valid = 0; e_sop = 0; e_eop = 0; e_scr = 0;
        if (v) begin
            x = int'($signed(d[15:0]));
            hist.push_back(x);
            if (hist.size() > LN) void'(hist.pop_front());
            ls = 0; ss = 0;
            for (int k = 0; k < hist.size(); k++) begin
                ls += hist[k];
                if (k >= hist.size() - SN) ss += hist[k];
            end
            dm = fdiv(ls, LN) - fdiv(ss, SN);
            case (mode)
                M_FILL: begin
                    cnt++;
                    if (cnt == LN) begin mode = M_SRCH; cnt = 0; end
                end
                M_SRCH: begin
                    if (dm > THR || -dm > THR) begin
                        mode = M_CAP; e_scr = 1; cnt = 0; fwd_k = 0;
                    end
                end
                M_CAP: begin
                    pos  = cnt % (SYM + CPL);
                    symn = cnt / (SYM + CPL);
                    cnt++;
                    if (pos >= CPL) begin
                        e_valid = 1; e_data = d; e_sop = (fwd_k == 0);
                        fwd_k++;
                        e_eop = (fwd_k == NPKT); e_sym = symn;
                    end
                    if (cnt == SPP * (SYM + CPL)) begin mode = M_HOLD; cnt = 0; end
                end
                default: begin
                    cnt++;
                    if (cnt == HOLD) begin mode = M_FILL; cnt = 0; hist.delete(); end
                end
            endcase
        end
    endtask

    task automatic cyc(input bit v, input logic [31:0] d);
        @(negedge clk);
        vin = v; din = d;
        @(posedge clk);
        #1;
        model_step(v, d);
        chk("valid", 32'(vout), 32'(e_valid));
        chk("sop", 32'(sop), 32'(e_sop));
        chk("eop", 32'(eop), 32'(e_eop));
        chk("sclk_reset", 32'(scr), 32'(e_scr));
        chk("sync_lock", 32'(lock), 32'(mode == M_CAP));
        chk("pre_sampling", 32'(pre), 32'(mode != M_CAP));
        if (e_valid) begin
            chk("data", dout, e_data);
            chk("symbol_index", 32'(symidx), 32'(e_sym));
        end
        obs_valid += int'(vout);
        obs_sop   += int'(sop);
        obs_eop   += int'(eop);
        obs_scr   += int'(scr);
    endtask

    task automatic clr_obs();
        obs_valid = 0; obs_sop = 0; obs_eop = 0; obs_scr = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(vout), 32'd0);
        chk({tag, "_sop"}, 32'(sop), 32'd0);
        chk({tag, "_eop"}, 32'(eop), 32'd0);
        chk({tag, "_data"}, dout, 32'd0);
        chk({tag, "_pre"}, 32'(pre), 32'd1);
        chk({tag, "_scr"}, 32'(scr), 32'd0);
        chk({tag, "_lock"}, 32'(lock), 32'd0);
        chk({tag, "_symidx"}, 32'(symidx), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; vin = 1'b0; din = '0;
        #1;
        model_reset();
        check_reset_vals(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] smp(input int i_val);
        logic [15:0] q;
        q = 16'($urandom);
        return {q, 16'(i_val)};
    endfunction

    initial begin
        rst = 1'b1; vin = 1'b0; din = '0;
        model_reset();
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;

        // constant level never triggers
        clr_obs();
        for (int i = 0; i < 200; i++) cyc(1'b1, smp(500));
        chk("const500_no_out", 32'(obs_valid), 32'd0);
        chk("const500_no_trig", 32'(obs_scr), 32'd0);

        // step 0 -> 1000, continuous valid
        do_reset("rst_a");
        clr_obs();
        for (int i = 0; i < 40; i++) cyc(1'b1, smp(0));
        cyc(1'b1, smp(1000));
        chk("step1000_trig", 32'(scr), 32'd1);
        for (int i = 0; i < 60; i++) cyc(1'b1, smp(1000));
        chk("step1000_nout", 32'(obs_valid), 32'(NPKT));
        chk("step1000_nsop", 32'(obs_sop), 32'd1);
        chk("step1000_neop", 32'(obs_eop), 32'd1);
        chk("step1000_nscr", 32'(obs_scr), 32'd1);

        // same step with valid on alternate cycles
        do_reset("rst_b");
        clr_obs();
        for (int i = 0; i < 40; i++) begin cyc(1'b1, smp(0)); cyc(1'b0, smp(77)); end
        for (int i = 0; i < 60; i++) begin cyc(1'b1, smp(1000)); cyc(1'b0, smp(-5)); end
        chk("toggle_nout", 32'(obs_valid), 32'(NPKT));
        chk("toggle_nsop", 32'(obs_sop), 32'd1);
        chk("toggle_neop", 32'(obs_eop), 32'd1);

        // reset at the 10th forwarded sample, then a full FILL without trigger
        do_reset("rst_c");
        clr_obs();
        for (int i = 0; i < 40; i++) cyc(1'b1, smp(0));
        for (int i = 0; i < 40 && obs_valid < 10; i++) cyc(1'b1, smp(1000));
        chk("midcap_seen10", 32'(obs_valid), 32'd10);
        do_reset("midcap");
        clr_obs();
        for (int i = 0; i < LN; i++) cyc(1'b1, smp((i % 2 == 0) ? 20000 : -20000));
        chk("fill_no_trig", 32'(obs_scr), 32'd0);
        chk("fill_no_eop", 32'(obs_eop), 32'd0);

        // small step stays below threshold
        do_reset("rst_d");
        clr_obs();
        for (int i = 0; i < 40; i++) cyc(1'b1, smp(0));
        for (int i = 0; i < 60; i++) cyc(1'b1, smp(100));
        chk("step100_no_trig", 32'(obs_scr), 32'd0);

        // 0 -> 200 step: sequence follows the model
        do_reset("rst_e");
        for (int i = 0; i < 40; i++) cyc(1'b1, smp(0));
        for (int i = 0; i < 30; i++) cyc(1'b1, smp(200));

        // 0 -> 500 step triggers on its first sample
        do_reset("rst_f");
        for (int i = 0; i < 40; i++) cyc(1'b1, smp(0));
        cyc(1'b1, smp(500));
        chk("step500_trig", 32'(scr), 32'd1);
        for (int i = 0; i < 60; i++) cyc(1'b1, smp(500));

        // randomized traffic: noisy levels with occasional jumps and gaps
        begin
            int base;
            base = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 59) == 0) base = int'($urandom_range(0, 6000)) - 3000;
                cyc($urandom_range(0, 3) != 0, smp(base + int'($urandom_range(0, 80)) - 40));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
